// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative signed multiply/divide sequencer for the multi-cycle
// MIPS datapath. Operands are latched on start. The unit then runs WIDTH
// shift-add (mult) or restoring-divide (div) steps. A sign-fix cycle follows,
// and the unit strobes HI/LO.
// Optional build macro MULT_DIV_UNSIGNED_EN adds the is_unsigned port
// (multu/divu: no absolute values, no sign fix).
//
// Handshake: start/op/operands are sampled at an edge only when the FSM is in
// IDLE and busy is low. busy, done, div_zero, hi_wr and lo_wr are registered
// decodes of the state held during the previous cycle. done therefore appears
// one cycle after the FSM enters DONE/DZ. busy drops one cycle after the FSM
// returns to IDLE. Operands are don't-care once accepted.
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_wr,
  output logic             lo_wr,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_FIX  = 3'd2,
    S_DONE = 3'd3,
    S_DZ   = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;     // 0 = mult, 1 = div
  logic               sa_q;     // sign of a (0 in unsigned mode)
  logic               sb_q;     // sign of b (0 in unsigned mode)
  logic [WIDTH-1:0]   mcand;    // |a| for mult, |b| (divisor) for div
  logic [2*WIDTH-1:0] acc;      // mult: {upper, multiplier/lower}; div: {rem, quot}

  // Signedness of the incoming request.
  logic signed_req;
`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_req = ~is_unsigned;
`else
  assign signed_req = 1'b1;
`endif

  // Operand sign and magnitude at accept time
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  // One iteration of each algorithm, and the sign-fixed results
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Datapath: operand conditioning, one loop step, and sign correction
  always_comb begin
    a_neg = a_in[WIDTH-1] & signed_req;
    b_neg = b_in[WIDTH-1] & signed_req;
    a_abs = a_neg ? (~a_in + 1'b1) : a_in;
    b_abs = b_neg ? (~b_in + 1'b1) : b_in;

    // Shift-add: conditionally add the multiplicand to the upper half,
    // then shift right with the carry entering the MSB.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs WIDTH+1 bits, because an
    // unsigned divisor can be as large as 2^WIDTH-1.
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    if (rem_sh >= {1'b0, mcand}) begin
      div_next = {(rem_sh[WIDTH-1:0] - mcand), acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    prod_fix = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
    quot_fix = (sa_q ^ sb_q) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = sa_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM with registered status outputs and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_wr    <= 1'b0;
      lo_wr    <= 1'b0;
      hi_res   <= '0;
      lo_res   <= '0;
    end else begin
      busy     <= (state != S_IDLE);
      done     <= (state == S_DONE) || (state == S_DZ);
      div_zero <= (state == S_DZ);
      hi_wr    <= (state == S_DONE);
      lo_wr    <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            op_q <= op;
            sa_q <= a_neg;
            sb_q <= b_neg;
            cnt  <= CNT_W'(WIDTH);
            if (op) begin
              mcand <= b_abs;
              acc   <= {{WIDTH{1'b0}}, a_abs};
            end else begin
              mcand <= a_abs;
              acc   <= {{WIDTH{1'b0}}, b_abs};
            end
            state <= (op && (b_in == '0)) ? S_DZ : S_RUN;
          end
        end
        S_RUN: begin
          acc <= op_q ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_q) begin
            hi_res <= rem_fix;
            lo_res <= quot_fix;
          end else begin
            hi_res <= prod_fix[2*WIDTH-1:WIDTH];
            lo_res <= prod_fix[WIDTH-1:0];
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_DZ:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: randomized and directed bench for mult_div_seq, with an
// arithmetic reference model of MIPS mult/div (and multu/divu when built with
// MULT_DIV_UNSIGNED_EN).
module tb_mult_div_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         uns = 1'b0;
  logic         busy, done, div_zero, hi_wr, lo_wr;
  logic [W-1:0] hi_res, lo_res;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  logic [W-1:0] exp_q[$];

  mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in),
`ifdef MULT_DIV_UNSIGNED_EN
    .is_unsigned(uns),
`endif
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_res(hi_res), .lo_res(lo_res)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics with plain 64-bit arithmetic.
  // Division truncates toward zero; the remainder takes the sign of the dividend.
  task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic u, output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    sa = u ? longint'({32'b0, a}) : longint'($signed(a));
    sb = u ? longint'({32'b0, b}) : longint'($signed(b));
    if (!o) begin
      p  = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      p  = 64'(q);
      lo = p[31:0];
      p  = 64'(r);
      hi = p[31:0];
    end
  endtask

  // Issue one operation and follow it to completion; poke = extra start at E10
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic u, input logic poke);
    logic [W-1:0] eh, el;
    logic dz;
    int lat;
    bit got;
    model(o, a, b, u, eh, el, dz);
    if (!dz) begin
      exp_q.push_back(eh);
      exp_q.push_back(el);
    end
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b; uns = u;
    @(posedge clock);                       // E0
    #1 start = 1'b0;
    a_in = $urandom; b_in = $urandom;       // don't-care after E0
    lat = 0;
    got = 0;
    while (!got && lat < 45) begin
      if (poke && lat == 9) begin
        start = 1'b1; op = ~o; a_in = $urandom_range(1, 1000); b_in = $urandom_range(1, 50);
      end
      @(posedge clock);
      lat++;
      #1 start = 1'b0;
      @(negedge clock);
      if (lat == 1) check("busy_after_e1", busy, 1);
      if (done) got = 1;
      else if (hi_wr | lo_wr | div_zero) check("early_strobe", {hi_wr, lo_wr, div_zero}, 0);
    end
    check("latency", lat, dz ? 1 : W + 2);
    check("div_zero", div_zero, dz);
    check("hi_wr", hi_wr, !dz);
    check("lo_wr", lo_wr, !dz);
    if (!dz) begin
      model_hi = exp_q.pop_front();
      model_lo = exp_q.pop_front();
    end
    check("hi_res", hi_res, model_hi);
    check("lo_res", lo_res, model_lo);
    @(posedge clock);
    @(negedge clock);
    check("pulse_end", {done, div_zero, hi_wr, lo_wr}, 0);
    check("busy_low", busy, 0);
    check("hi_hold", hi_res, model_hi);
    check("lo_hold", lo_res, model_lo);
  endtask

  function automatic logic [W-1:0] pick(input bit allow_zero);
    case ($urandom_range(0, 7))
      0: return allow_zero ? 32'h0 : 32'h1;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", {busy, done, div_zero, hi_wr, lo_wr}, 0);
    check("rst_hi", hi_res, 0);
    check("rst_lo", lo_res, 0);
    reset = 1'b0;

    // Directed cases
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    check("mul_7_m3_hi", hi_res, 32'hFFFF_FFFF);
    check("mul_7_m3_lo", lo_res, 32'hFFFF_FFEB);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_m7_2_lo", lo_res, 32'hFFFF_FFFD);
    check("div_m7_2_hi", hi_res, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
    check("div_100_7_lo", lo_res, 32'd14);
    check("div_100_7_hi", hi_res, 32'd2);
    run_op(1'b0, 32'd3, 32'd7, 1'b0, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
    check("dz_hi_kept", hi_res, 32'h0);
    check("dz_lo_kept", lo_res, 32'h15);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("ovf_lo", lo_res, 32'h8000_0000);
    check("ovf_hi", hi_res, 32'h0);

    // Reset in the middle of a multiply
    @(negedge clock);
    start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd4; uns = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (11) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);                       // E12
    #1 reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi_res, 0);
    check("mid_rst_lo", lo_res, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done | hi_wr | lo_wr | busy) check("mid_rst_quiet", {done, hi_wr, lo_wr, busy}, 0);
    end
    run_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0);
    check("after_rst_lo", lo_res, 32'd12);

`ifdef MULT_DIV_UNSIGNED_EN
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("multu_hi", hi_res, 32'hFFFF_FFFE);
    check("multu_lo", lo_res, 32'h0000_0001);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    check("divu_lo", lo_res, 32'h7FFF_FFFF);
    check("divu_hi", hi_res, 32'd1);
`endif

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic rnd_u;
`ifdef MULT_DIV_UNSIGNED_EN
      rnd_u = 1'($urandom_range(0, 1));
`else
      rnd_u = 1'b0;
`endif
      run_op(1'($urandom_range(0, 1)), pick(1'b1), pick($urandom_range(0, 5) == 0),
             rnd_u, 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
